// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Sequences one radar frame from the sample ROM streamer into the range-FFT core.
//   Sends a single FFT config word and then gates the streamer enable chirp by chirp.
//   The streamer output has no backpressure, so it is re-timed through a small FIFO.
//   Enables are issued only while the FIFO has room for every sample still in flight.
//   The FIFO drives an AXI-Stream master with tlast on the final beat of each chirp.
//   Idle gaps are inserted between chirps, and frame_done pulses once at frame end.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, abort        frame start request (IDLE only) / abandon frame
//   busy, frame_done    status: not IDLE / one-cycle frame complete pulse
//   chirp_idx           current chirp number
//   src_enable          streamer enable (sample valid one cycle later)
//   src_tdata/tvalid    streamer output, no backpressure
//   cfg_tdata/tvalid/tready  FFT config stream (one beat per frame)
//   m_tdata/tvalid/tready/tlast  FFT sample stream
module fft_frame_sequencer #(
  parameter int unsigned          DATA_WIDTH        = 32,
  parameter int unsigned          SAMPLES_PER_CHIRP = 256,
  parameter int unsigned          CHIRPS_PER_FRAME  = 128,
  parameter int unsigned          GAP_CYCLES        = 16,
  parameter int unsigned          CFG_WIDTH         = 16,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD          = CFG_WIDTH'(1),
  parameter int unsigned          FIFO_DEPTH        = 4,
  localparam int unsigned ChirpW = (CHIRPS_PER_FRAME > 1) ? $clog2(CHIRPS_PER_FRAME) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ChirpW-1:0]     chirp_idx,
  output logic                  src_enable,
  input  logic [DATA_WIDTH-1:0] src_tdata,
  input  logic                  src_tvalid,
  output logic [CFG_WIDTH-1:0]  cfg_tdata,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int unsigned SampW = $clog2(SAMPLES_PER_CHIRP + 1);
  localparam int unsigned OutW  = $clog2(SAMPLES_PER_CHIRP);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [SampW-1:0]  SampTotal = SampW'(SAMPLES_PER_CHIRP);
  localparam logic [OutW-1:0]   OutLast   = OutW'(SAMPLES_PER_CHIRP - 1);
  localparam logic [ChirpW-1:0] ChirpLast = ChirpW'(CHIRPS_PER_FRAME - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CntW:0]     DepthC    = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StCfg, StStream, StDrain, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               cfg_tvalid_q, cfg_tvalid_d;
  logic               src_enable_q, src_enable_d;
  logic [ChirpW-1:0]  chirp_q, chirp_d;
  logic [SampW-1:0]   issued_q, issued_d;
  logic [OutW-1:0]    out_cnt_q, out_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW:0]      credit;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, last_acc;

  // Samples are only accepted while a chirp is active; anything else is stale.
  assign push     = src_tvalid && ((state_q == StStream) || (state_q == StDrain));
  assign m_tvalid = (count_q != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tlast  = m_tvalid && (out_cnt_q == OutLast);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign last_acc = pop && m_tlast;

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_tvalid = cfg_tvalid_q;
  assign src_enable = src_enable_q;
  assign chirp_idx  = chirp_q;
  assign cfg_tdata  = CFG_WORD;

  always_comb begin
    state_d   = state_q;
    chirp_d   = chirp_q;
    issued_d  = issued_q;
    out_cnt_d = out_cnt_q;
    gap_cnt_d = gap_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      out_cnt_d = m_tlast ? '0 : out_cnt_q + OutW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (src_enable_q) issued_d = issued_q + SampW'(1);

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StCfg;
      end
      StCfg: begin
        if (cfg_tvalid_q && cfg_tready) begin
          state_d  = StStream;
          issued_d = '0;
        end
      end
      StStream: begin
        if (issued_q == SampTotal) state_d = StDrain;
      end
      StDrain: begin
        if (last_acc) begin
          if (chirp_q == ChirpLast) begin
            state_d = StDone;
          end else if (GAP_CYCLES == 0) begin
            state_d  = StStream;
            chirp_d  = chirp_q + ChirpW'(1);
            issued_d = '0;
          end else begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d  = StStream;
          chirp_d  = chirp_q + ChirpW'(1);
          issued_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        chirp_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      chirp_d   = '0;
      issued_d  = '0;
      out_cnt_d = '0;
      gap_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end

    // Next-cycle credit: the enable issued this cycle becomes the in-flight sample.
    credit = {1'b0, count_d} + {{CntW{1'b0}}, src_enable_q};

    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StDone);
    cfg_tvalid_d = (state_d == StCfg);
    src_enable_d = (state_d == StStream) && (issued_d < SampTotal) && (credit < DepthC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_tvalid_q <= 1'b0;
      src_enable_q <= 1'b0;
      chirp_q      <= '0;
      issued_q     <= '0;
      out_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      src_enable_q <= src_enable_d;
      chirp_q      <= chirp_d;
      issued_q     <= issued_d;
      out_cnt_q    <= out_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= src_tdata;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
  localparam int N   = 4;
  localparam int C   = 3;
  localparam int GAP = 2;
  localparam int D   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic cfg_tready = 1'b1, m_tready = 1'b1, rewind = 1'b0, sel = 1'b0;
  int   rdy_mode = 0;

  logic        a_busy, a_frame_done, a_src_enable, a_cfg_tvalid, a_m_tvalid, a_m_tlast;
  logic [1:0]  a_chirp_idx;
  logic [15:0] a_cfg_tdata;
  logic [31:0] a_m_tdata, a_src_tdata;
  logic        a_src_tvalid;
  logic        b_busy, b_frame_done, b_src_enable, b_cfg_tvalid, b_m_tvalid, b_m_tlast;
  logic [1:0]  b_chirp_idx;
  logic [15:0] b_cfg_tdata;
  logic [31:0] b_m_tdata, b_src_tdata;
  logic        b_src_tvalid;

  fft_frame_sequencer #(.DATA_WIDTH(32), .SAMPLES_PER_CHIRP(N), .CHIRPS_PER_FRAME(C),
    .GAP_CYCLES(GAP), .CFG_WIDTH(16), .CFG_WORD(16'h0001), .FIFO_DEPTH(D)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .busy(a_busy),
    .frame_done(a_frame_done), .chirp_idx(a_chirp_idx), .src_enable(a_src_enable),
    .src_tdata(a_src_tdata), .src_tvalid(a_src_tvalid), .cfg_tdata(a_cfg_tdata),
    .cfg_tvalid(a_cfg_tvalid), .cfg_tready(cfg_tready), .m_tdata(a_m_tdata),
    .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tlast(a_m_tlast));

  fft_frame_sequencer #(.DATA_WIDTH(32), .SAMPLES_PER_CHIRP(N), .CHIRPS_PER_FRAME(C),
    .GAP_CYCLES(0), .CFG_WIDTH(16), .CFG_WORD(16'h0001), .FIFO_DEPTH(D)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .busy(b_busy),
    .frame_done(b_frame_done), .chirp_idx(b_chirp_idx), .src_enable(b_src_enable),
    .src_tdata(b_src_tdata), .src_tvalid(b_src_tvalid), .cfg_tdata(b_cfg_tdata),
    .cfg_tvalid(b_cfg_tvalid), .cfg_tready(cfg_tready), .m_tdata(b_m_tdata),
    .m_tvalid(b_m_tvalid), .m_tready(m_tready), .m_tlast(b_m_tlast));

  // Sample ROM streamers: one enable yields one sample a cycle later, in ROM order.
  logic [31:0] rom [64];
  logic [5:0]  a_ptr, b_ptr;
  always @(posedge clk) begin
    if (rst || rewind) begin
      a_src_tvalid <= 1'b0; a_ptr <= '0; a_src_tdata <= '0;
      b_src_tvalid <= 1'b0; b_ptr <= '0; b_src_tdata <= '0;
    end else begin
      a_src_tvalid <= a_src_enable;
      b_src_tvalid <= b_src_enable;
      if (a_src_enable) begin a_src_tdata <= rom[a_ptr]; a_ptr <= a_ptr + 6'd1; end
      if (b_src_enable) begin b_src_tdata <= rom[b_ptr]; b_ptr <= b_ptr + 6'd1; end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 9) < 3);
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mon_busy, mon_done, mon_en, mon_cv, mon_mv, mon_ml;
  logic [1:0]  mon_ci;
  logic [15:0] mon_cd;
  logic [31:0] mon_md;
  assign mon_busy = sel ? b_busy : a_busy;
  assign mon_done = sel ? b_frame_done : a_frame_done;
  assign mon_en   = sel ? b_src_enable : a_src_enable;
  assign mon_cv   = sel ? b_cfg_tvalid : a_cfg_tvalid;
  assign mon_cd   = sel ? b_cfg_tdata : a_cfg_tdata;
  assign mon_mv   = sel ? b_m_tvalid : a_m_tvalid;
  assign mon_ml   = sel ? b_m_tlast : a_m_tlast;
  assign mon_md   = sel ? b_m_tdata : a_m_tdata;
  assign mon_ci   = sel ? b_chirp_idx : a_chirp_idx;

  // Observation log of the selected DUT
  logic [31:0] bd[$];
  bit          bl[$];
  int          bi[$], bc[$];
  int cfg_cnt, cfg_hi, cfg_cyc, cfg_viol, en_cfg, done_cnt, done_cyc;
  int stall_viol, occ_viol, valid_idle, iss_tot, acc_tot;
  logic [15:0] cfg_data, prev_cd;
  logic [31:0] prev_md;
  bit prev_stall, prev_ml, prev_cstall;

  always @(negedge clk) begin
    if (mon_en) iss_tot = iss_tot + 1;
    if (iss_tot - acc_tot > D) occ_viol = occ_viol + 1;
    if (prev_stall && (!mon_mv || mon_md !== prev_md || mon_ml !== prev_ml))
      stall_viol = stall_viol + 1;
    prev_stall = mon_mv && !m_tready; prev_md = mon_md; prev_ml = mon_ml;
    if (mon_mv && m_tready) begin
      bd.push_back(mon_md); bl.push_back(mon_ml); bi.push_back(int'(mon_ci));
      bc.push_back(cyc); acc_tot = acc_tot + 1;
    end
    if (mon_cv) cfg_hi = cfg_hi + 1;
    if (mon_cv && mon_en) en_cfg = en_cfg + 1;
    if (prev_cstall && (!mon_cv || mon_cd !== prev_cd)) cfg_viol = cfg_viol + 1;
    prev_cstall = mon_cv && !cfg_tready; prev_cd = mon_cd;
    if (mon_cv && cfg_tready) begin cfg_cnt = cfg_cnt + 1; cfg_cyc = cyc; cfg_data = mon_cd; end
    if (mon_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (mon_mv && !mon_busy) valid_idle = valid_idle + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic clear_logs();
    @(posedge clk); #1;
    bd.delete(); bl.delete(); bi.delete(); bc.delete();
    cfg_cnt = 0; cfg_hi = 0; cfg_cyc = 0; cfg_viol = 0; en_cfg = 0; done_cnt = 0;
    done_cyc = 0; stall_viol = 0; occ_viol = 0; valid_idle = 0; iss_tot = 0; acc_tot = 0;
    prev_stall = 0; prev_cstall = 0;
  endtask

  task automatic rewind_src();
    @(posedge clk); #1 rewind = 1'b1;
    @(posedge clk); #1 rewind = 1'b0;
  endtask

  task automatic start_frame(input bit which);
    @(posedge clk); #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(posedge clk); n++; end
    ok = (done_cnt > 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int nb, input int budget, output bit ok);
    int n = 0;
    while (bd.size() < nb && n < budget) begin @(posedge clk); n++; end
    ok = (bd.size() >= nb);
  endtask

  // Reference: beat k of a frame from a rewound streamer is ROM word k, tlast closes each
  // chirp of N beats, and it belongs to chirp k/N.
  function automatic int frame_errs();
    int e = 0;
    if (bd.size() != N * C) e++;
    for (int k = 0; k < bd.size() && k < N * C; k++) begin
      bit exp_last = ((k % N) == N - 1);
      if (bd[k] !== rom[k]) e++;
      if (bl[k] !== exp_last) e++;
      if (bi[k] != k / N) e++;
    end
    return e;
  endfunction

  // Reference timing with m_tready held high: data starts 3 cycles after the config
  // handshake (state change + 2-cycle fill), beats within a chirp are back to back, the
  // next chirp's first beat comes gap+3 cycles after tlast, and frame_done follows tlast.
  function automatic int timing_errs(input int gap);
    int e = 0;
    if (bc.size() != N * C) return 1;
    if (bc[0] != cfg_cyc + 3) e++;
    for (int k = 1; k < N * C; k++) begin
      int exp_c = ((k % N) == 0) ? bc[k-1] + gap + 3 : bc[k-1] + 1;
      if (bc[k] != exp_c) e++;
    end
    if (done_cyc != bc[N*C-1] + 1) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_a = 0; start_b = 0; abort = 0; cfg_tready = 1; rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({a_busy, a_frame_done, a_src_enable, a_cfg_tvalid, a_m_tvalid, a_m_tlast} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {a_busy, a_frame_done, a_src_enable, a_cfg_tvalid, a_m_tvalid, a_m_tlast});
    end
    n_cmp++;
    if (a_chirp_idx !== 2'd0) begin
      n_err++; $display("FAIL reset_chirp_idx: got %0d, expected 0", a_chirp_idx);
    end
    n_cmp++;
    if ({b_busy, b_src_enable, b_cfg_tvalid, b_m_tvalid} !== 4'b0) begin
      n_err++; $display("FAIL reset_outputs_b: got %b, expected 0000",
                        {b_busy, b_src_enable, b_cfg_tvalid, b_m_tvalid});
    end
  endtask

  task automatic test_basic();
    bit ok; int e;
    sel = 0; rdy_mode = 0; cfg_tready = 1;
    rewind_src(); clear_logs(); start_frame(0); wait_done(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_timeout: got no frame_done, expected one"); end
    n_cmp++;
    if (cfg_cnt != 1 || cfg_data !== 16'h0001) begin
      n_err++; $display("FAIL basic_cfg: got %0d beats data %h, expected 1 beat 0001",
                        cfg_cnt, cfg_data);
    end
    e = frame_errs(); n_cmp++;
    if (e != 0) begin n_err++; $display("FAIL basic_frame: got %0d errors (%0d beats), expected 0",
                                        e, bd.size()); end
    e = timing_errs(GAP); n_cmp++;
    if (e != 0) begin n_err++; $display("FAIL basic_timing: got %0d errors, expected 0", e); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL basic_done: got %0d, expected 1", done_cnt); end
    n_cmp++;
    if (a_busy !== 1'b0 || a_chirp_idx !== 2'd0) begin
      n_err++; $display("FAIL basic_idle: got busy=%b idx=%0d, expected 0/0", a_busy, a_chirp_idx);
    end
  endtask

  task automatic test_cfg_stall();
    bit ok; int e;
    sel = 0; rdy_mode = 0; cfg_tready = 0;
    rewind_src(); clear_logs(); start_frame(0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (a_cfg_tvalid !== 1'b1 || en_cfg != 0 || a_src_enable !== 1'b0) begin
      n_err++; $display("FAIL cfg_hold: got valid=%b en=%0d, expected valid=1 en=0",
                        a_cfg_tvalid, en_cfg);
    end
    @(posedge clk); #1 cfg_tready = 1;
    wait_done(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL cfg_timeout: got no frame_done, expected one"); end
    n_cmp++;
    if (cfg_hi != 6 || cfg_viol != 0 || en_cfg != 0 || cfg_cnt != 1) begin
      n_err++; $display("FAIL cfg_stall: got hi=%0d viol=%0d en=%0d cnt=%0d, expected 6/0/0/1",
                        cfg_hi, cfg_viol, en_cfg, cfg_cnt);
    end
    e = frame_errs(); n_cmp++;
    if (e != 0) begin n_err++; $display("FAIL cfg_frame: got %0d errors, expected 0", e); end
  endtask

  task automatic test_stall();
    bit ok; int e;
    for (int m = 1; m <= 2; m++) begin
      sel = 0; rdy_mode = m; cfg_tready = 1;
      rewind_src(); clear_logs(); start_frame(0); wait_done(2000, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL stall_timeout mode %0d: no frame_done", m); end
      e = frame_errs(); n_cmp++;
      if (e != 0) begin n_err++; $display("FAIL stall_frame mode %0d: got %0d errors, expected 0",
                                          m, e); end
      n_cmp++;
      if (stall_viol != 0 || occ_viol != 0) begin
        n_err++; $display("FAIL stall_rules mode %0d: got stable=%0d occ=%0d, expected 0/0",
                          m, stall_viol, occ_viol);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_abort();
    bit ok; int e, nb;
    sel = 0; rdy_mode = 0; cfg_tready = 1;
    rewind_src(); clear_logs(); start_frame(0);
    wait_beats(N + 3, 500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL abort_reach: got %0d beats, expected %0d", bd.size(), N+3); end
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    n_cmp++;
    if ({a_m_tvalid, a_busy, a_src_enable, a_cfg_tvalid} !== 4'b0) begin
      n_err++; $display("FAIL abort_idle: got %b, expected 0000",
                        {a_m_tvalid, a_busy, a_src_enable, a_cfg_tvalid});
    end
    nb = bd.size();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (bd.size() != nb || valid_idle != 0 || done_cnt != 0) begin
      n_err++; $display("FAIL abort_quiet: got beats+%0d idlevalid=%0d done=%0d, expected 0/0/0",
                        bd.size() - nb, valid_idle, done_cnt);
    end
    rewind_src(); clear_logs(); start_frame(0);
    n_cmp++;
    if (a_chirp_idx !== 2'd0 || a_cfg_tvalid !== 1'b1) begin
      n_err++; $display("FAIL abort_restart: got idx=%0d cfg=%b, expected 0/1",
                        a_chirp_idx, a_cfg_tvalid);
    end
    wait_done(500, ok);
    e = frame_errs(); n_cmp++;
    if (!ok || e != 0 || cfg_cnt != 1) begin
      n_err++; $display("FAIL abort_refrm: got done=%b errors=%0d cfg=%0d, expected 1/0/1",
                        ok, e, cfg_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit ok; int e;
    sel = 0; rdy_mode = 0; cfg_tready = 1;
    @(posedge clk); #1 start_a = 1; abort = 1;
    @(posedge clk); #1 start_a = 0; abort = 0;
    n_cmp++;
    if (a_busy !== 1'b0 || a_cfg_tvalid !== 1'b0) begin
      n_err++; $display("FAIL start_abort_idle: got busy=%b cfg=%b, expected 0/0",
                        a_busy, a_cfg_tvalid);
    end
    rewind_src(); clear_logs(); start_frame(0);
    for (int p = 0; p < 2; p++) begin
      wait_beats(2 + 5 * p, 500, ok);
      @(posedge clk); #1 start_a = 1;
      @(posedge clk); #1 start_a = 0;
    end
    wait_done(500, ok);
    repeat (30) @(posedge clk);
    #1;
    e = frame_errs(); n_cmp++;
    if (!ok || done_cnt != 1 || e != 0 || cfg_cnt != 1) begin
      n_err++; $display("FAIL start_busy: got done=%0d errors=%0d cfg=%0d, expected 1/0/1",
                        done_cnt, e, cfg_cnt);
    end
  endtask

  task automatic test_no_gap();
    bit ok; int e;
    sel = 1; rdy_mode = 0; cfg_tready = 1;
    rewind_src(); clear_logs(); start_frame(1); wait_done(500, ok);
    e = frame_errs(); n_cmp++;
    if (!ok || e != 0) begin
      n_err++; $display("FAIL nogap_frame: got done=%b errors=%0d, expected 1/0", ok, e);
    end
    e = timing_errs(0); n_cmp++;
    if (e != 0) begin n_err++; $display("FAIL nogap_timing: got %0d errors, expected 0", e); end
    n_cmp++;
    if (done_cnt != 1 || occ_viol != 0) begin
      n_err++; $display("FAIL nogap_done: got done=%0d occ=%0d, expected 1/0", done_cnt, occ_viol);
    end
    sel = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    test_reset();
    test_basic();
    test_cfg_stall();
    test_stall();
    test_abort();
    test_start_ignored();
    test_no_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
